alu_seq: RTL and testbench

- Parametrised, registered successor to the team's 4-bit combinational ALU (adder, subtractor, comparator, one's complement).
- Generalised to WIDTH bits, with an opcode-selected operation and a valid/ready handshake on both input and output.
- Adds a multi-cycle unsigned shift-add multiplier.
- Sits between the operand register file and the result writeback stage of the datapath.

---
 rtl/alu_seq.sv | 149 ++++++++++++++
 tb/tb_alu_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshakes: single-cycle ADD/SUB/CMP/NOT,
// a WIDTH-iteration unsigned shift-add multiplier, and illegal-opcode reporting.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic             cout,
    output logic             ovfw,
    output logic             eq,
    output logic             lt_s,
    output logic             zero,
    output logic             err
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_CMP = 3'd2;
    localparam logic [2:0] OP_NOT = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   res_q, res_hi_q, mcand_q, mplier_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q;
    logic               cout_q, ovfw_q, eq_q, lt_s_q, zero_q, err_q;

    logic [WIDTH:0]     sum_d, diff_d;
    logic               add_ovf_d, sub_ovf_d;
    logic [WIDTH-1:0]   res_d;
    logic               cout_d, ovfw_d, err_d;

    always_comb begin
        sum_d     = {1'b0, a} + {1'b0, b};
        diff_d    = {1'b0, a} - {1'b0, b};
        add_ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum_d[WIDTH-1] != a[WIDTH-1]);
        sub_ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff_d[WIDTH-1] != a[WIDTH-1]);
        res_d     = '0;
        cout_d    = 1'b0;
        ovfw_d    = 1'b0;
        err_d     = 1'b0;
        case (op)
            OP_ADD: begin
                res_d  = sum_d[WIDTH-1:0];
                cout_d = sum_d[WIDTH];
                ovfw_d = add_ovf_d;
            end
            OP_SUB, OP_CMP: begin
                res_d  = diff_d[WIDTH-1:0];
                cout_d = diff_d[WIDTH];
                ovfw_d = sub_ovf_d;
            end
            OP_NOT:  res_d = ~a;
            OP_MUL:  ;
            default: err_d = 1'b1;
        endcase
    end

    // One partial product per cycle: multiplicand shifted to the current bit position.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0])
            acc_d = acc_q + ({{WIDTH{1'b0}}, mcand_q} << cnt_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            res_q    <= '0;
            res_hi_q <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            cout_q   <= 1'b0;
            ovfw_q   <= 1'b0;
            eq_q     <= 1'b0;
            lt_s_q   <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        eq_q   <= (a == b);
                        lt_s_q <= diff_d[WIDTH-1] ^ sub_ovf_d;
                        if (op == OP_MUL) begin
                            mcand_q  <= a;
                            mplier_q <= b;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            cout_q   <= 1'b0;
                            ovfw_q   <= 1'b0;
                            err_q    <= 1'b0;
                            state_q  <= S_MUL;
                        end else begin
                            res_q    <= res_d;
                            res_hi_q <= '0;
                            cout_q   <= cout_d;
                            ovfw_q   <= ovfw_d;
                            err_q    <= err_d;
                            zero_q   <= (res_d == '0);
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        {res_hi_q, res_q} <= acc_d;
                        zero_q            <= (acc_d == '0);
                        state_q           <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !reset;
    assign out_valid = (state_q == S_DONE);
    assign res       = res_q;
    assign res_hi    = res_hi_q;
    assign cout      = cout_q;
    assign ovfw      = ovfw_q;
    assign eq        = eq_q;
    assign lt_s      = lt_s_q;
    assign zero      = zero_q;
    assign err       = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver pushes reference results at accept time,
// the monitor pops and compares whenever a result is presented.
module tb_alu_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] res, res_hi;
    logic         cout, ovfw, eq, lt_s, zero, err;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .res_hi(res_hi), .cout(cout), .ovfw(ovfw), .eq(eq),
        .lt_s(lt_s), .zero(zero), .err(err)
    );

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         cout, ovfw, eq, lt_s, zero, err;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t           sb[$];
    int             cyc = 0;
    int             n_vec = 0;
    int             n_fail = 0;
    int             hs_cyc = -1;
    int             rdy_mode = 2;
    logic           mon_prev = 1'b0;
    logic [2*W+5:0] mon_hold = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned/signed operand values.
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int ua, ub, sa, sb_, r, s;
        e = '{default: 0};
        ua = x; ub = y; sa = $signed(x); sb_ = $signed(y);
        e.eq = (ua == ub);
        e.lt_s = (sa < sb_);
        e.lat = 1;
        case (o)
            3'd0: begin
                r = ua + ub; e.res = r[W-1:0]; e.cout = (r > 255);
                s = sa + sb_; e.ovfw = (s > 127) || (s < -128);
            end
            3'd1, 3'd2: begin
                r = ua - ub; e.res = r[W-1:0]; e.cout = (ua < ub);
                s = sa - sb_; e.ovfw = (s > 127) || (s < -128);
            end
            3'd3: e.res = ~x;
            3'd4: begin
                r = ua * ub; e.res = r[W-1:0]; e.hi = r[2*W-1:W]; e.lat = W + 1;
            end
            default: e.err = 1'b1;
        endcase
        e.zero = (e.res == 0) && (e.hi == 0);
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'hFF;
            2: return 8'h80;
            3: return 8'h7F;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output int acc);
        int t;
        exp_t e;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1; t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        acc = cyc;
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        e = model(o, x, y);
        e.acc_cyc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    // Consumer ready: random, forced low, or forced high.
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: out_ready = ($urandom_range(0, 2) != 0);
            1: out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (reset) begin
            mon_prev = 1'b0;
        end else begin
            if (out_valid) begin
                chk("in_ready_while_done", in_ready, 0);
                if (!mon_prev) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out_valid", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("latency", cyc - e.acc_cyc, e.lat);
                        chk("res", res, e.res);
                        chk("res_hi", res_hi, e.hi);
                        chk("flags{cout,ovfw,eq,lt_s,zero,err}", {cout, ovfw, eq, lt_s, zero, err},
                            {e.cout, e.ovfw, e.eq, e.lt_s, e.zero, e.err});
                    end
                    mon_hold = {res, res_hi, cout, ovfw, eq, lt_s, zero, err};
                end else begin
                    chk("held_stable", {res, res_hi, cout, ovfw, eq, lt_s, zero, err}, mon_hold);
                end
                if (out_ready) hs_cyc = cyc;
            end
            mon_prev = out_valid && !out_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int seen;
        logic [2:0] ro;
        #3;
        chk("rst_outputs", {out_valid, res, res_hi, cout, ovfw, eq, lt_s, zero, err}, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("in_ready_after_rst", in_ready, 1);
        chk("out_valid_after_rst", out_valid, 0);

        rdy_mode = 2;
        issue(3'd0, 8'h7F, 8'h01, acc);
        issue(3'd1, 8'h03, 8'h05, acc);
        issue(3'd2, 8'h80, 8'h01, acc);
        issue(3'd4, 8'hFF, 8'hFF, acc);
        issue(3'd4, 8'h00, 8'h37, acc);
        issue(3'd7, 8'h10, 8'h10, acc);
        issue(3'd3, 8'h5A, 8'h00, acc);
        drain();

        // Back-pressure: result held while the consumer stalls; new request waits.
        rdy_mode = 1;
        @(negedge clk);
        issue(3'd0, 8'hFF, 8'h01, acc);
        repeat (5) begin
            @(negedge clk);
            op = 3'd1; a = 8'h09; b = 8'h03; in_valid = 1'b1;
            chk("no_accept_while_done", in_ready, 0);
        end
        rdy_mode = 2;
        issue(3'd1, 8'h09, 8'h03, acc);
        chk("accept_after_handshake", acc, hs_cyc + 1);
        drain();

        // Asynchronous reset in the middle of a multiply.
        issue(3'd4, 8'hC3, 8'h5A, acc);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_outputs", {out_valid, res, res_hi, cout, ovfw, eq, lt_s, zero, err}, 0);
        chk("abort_in_ready", in_ready, 0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("in_ready_after_abort", in_ready, 1);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("no_valid_after_abort", seen, 0);
        issue(3'd3, 8'h5A, 8'h00, acc);
        drain();

        rdy_mode = 0;
        for (int i = 0; i < 300; i++) begin
            ro = 3'($urandom_range(0, 7));
            issue(ro, pick(), pick(), acc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rdy_mode = 2;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
